id_stage: RTL and testbench
===========================

# id_stage

Parametrised successor to the RV32 decode stage. Decodes one instruction per cycle from IF and resolves operands from the regfile plus NUM_FWD forwarding sources. Detects load-use hazards and stalls IF. Holds an internal ID/EX pipeline register with a valid/ready handshake toward EX and a synchronous flush from ctrl.

## Interface
- XLEN, 32: operand/immediate width (32 or 64); immediates sign-extend to XLEN.
- NUM_FWD, 2: forwarding sources; index 0 = youngest (EX), highest priority.
- STALL_CNT_W, 16: width of the saturating load-use stall counter.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset (`RstEnable`).
- if_valid_i / id_ready_o  in/out  1  IF handshake; transfer when both high at the clk edge.
- pc_i, inst_i, pc_invalid_i  in  32/32/1  fetched PC, instruction, PC-fault flag.
- reg1_read_o, reg2_read_o  out  1  regfile read enables (combinational).
- reg1_addr_o, reg2_addr_o  out  5  inst_i[19:15], inst_i[24:20] (combinational).
- reg1_data_i, reg2_data_i  in  XLEN  regfile read data.
- fwd_wreg_i  in  NUM_FWD  source i writes a register.
- fwd_wd_i  in  5*NUM_FWD  destination of source i.
- fwd_wdata_i  in  XLEN*NUM_FWD  result of source i.
- fwd_pending_i  in  NUM_FWD  source i result not yet available (load in flight).
- flush_i  in  1  discard the held ID/EX entry and the current input.
- ex_valid_o / ex_ready_i  out/in  1  EX handshake.
- aluop_o  out  `AluOpBus  `EXE_*_OP code.
- wd_o, wreg_o  out  5/1  destination and write enable.
- reg1_o, reg2_o, imm_o  out  XLEN  resolved operands and immediate.
- pc_o, inst_o  out  32  captured PC and instruction.
- pc_invalid_o, inst_invalid_o  out  1  fault flags (`InstInvalid` = undecodable).
- stallreq_o  out  1  load-use stall request to ctrl (combinational).
- stall_cnt_o  out  STALL_CNT_W  count of load-use stall cycles.

## Operation
- Decode set: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM (ADDI…SRAI), OP (ADD…AND, SUB, SRA).
- Immediates: I, S, B, U, J formats, sign-extended to XLEN; B/J bit 0 = 0; U = {inst[31:12], 12'h0} sign-extended.
- Read enables follow the format: U/J read none; I-type reads rs1; R/S/B-type read rs1 and rs2.
- Any unrecognised opcode/funct: inst_invalid_o=`InstInvalid, aluop=`EXE_NOP_OP, wreg=0. The entry still issues so ctrl can trap.
- Operand resolution per port, in priority order:
  - address 0 → 0, no hazard;
  - lowest i with fwd_wreg_i[i] && fwd_wd_i[i]==addr: if pending, hazard; else fwd_wdata_i[i];
  - otherwise regfile data.
- An unread port yields 0.
- A hazard on either read port sets stallreq_o=1. It is not evaluated when if_valid_i=0.
- id_ready_o = !rst && !flush_i && !hazard && (!ex_valid_o || ex_ready_i).
- Register update priority:
  - rst: clear everything;
  - flush_i: ex_valid_o←0;
  - accept: load all outputs, ex_valid_o←1;
  - ex_ready_i with no accept: ex_valid_o←0 (bubble);
  - else: hold every output.
- stall_cnt_o increments on each cycle with stallreq_o=1 and saturates at all-ones.

## Timing
- Latency is one cycle: an instruction accepted at edge N appears on the EX outputs after edge N.
- Full throughput (one per cycle) when there is no hazard and ex_ready_i=1.
- While ex_valid_o && !ex_ready_i, all EX outputs stay stable.
- A load-use stall lasts until fwd_pending_i drops for the matching source, with no extra cycles. While stalled, EX receives bubbles if ex_ready_i=1.
- flush_i wins over a simultaneous accept; the input instruction is dropped.
- rst asserted mid-stall or mid-hold: next cycle ex_valid_o=0, all data outputs 0, aluop=`EXE_NOP_OP, wd=0, wreg=0, inst_invalid_o=`InstValid, pc_invalid_o=0, stall_cnt_o=0.

## Test plan
- Basic ALU issue: rf x1=5, x2=7, issue ADD x3,x1,x2 → next cycle ex_valid_o=1, reg1_o=5, reg2_o=7, wd_o=3, wreg_o=1, aluop_o=`EXE_ADD_OP.
- Forward priority: fwd0 (wd=1, data 0xAA) and fwd1 (wd=1, data 0xBB) both valid, ADDI x4,x1,-1 → reg1_o=0xAA, imm_o=0xFFFFFFFF.
- Load-use stall: fwd0 pending with wd=2 for 3 cycles, SW x2,8(x1) → id_ready_o=0 and stallreq_o=1 for 3 cycles, 3 bubbles to EX, stall_cnt_o=3. Accepted on the 4th cycle with reg2_o=fwd0 data.
- x0 rule: fwd0 has wd=0, wreg=1, pending=1, data 0x55; ADD x5,x0,x0 → no stall, reg1_o=reg2_o=0.
- Backpressure and flush: ex_ready_i=0 for 4 cycles → outputs stable, id_ready_o=0. Then flush_i for 1 cycle → ex_valid_o=0 next cycle.
- Immediates and invalid decode: BEQ with offset −8 → imm_o=0xFFFFFFF8, wreg_o=0. Opcode 7'h7F → inst_invalid_o=`InstInvalid, aluop_o=`EXE_NOP_OP. rst mid-hold → all outputs at reset values.

Source files
------------

// File: rtl/id_stage_if.sv
// ==== id_stage_if : ID-stage bundle (IF, regfile, forwarding, EX) and decode codes -- rev 1.0 ====
`default_nettype none

`ifndef ID_STAGE_DEFS
`define ID_STAGE_DEFS
`define RstEnable     1'b1
`define InstValid     1'b0
`define InstInvalid   1'b1
`define AluOpBus      7:0
`define EXE_NOP_OP    8'd0
`define EXE_ADD_OP    8'd1
`define EXE_SUB_OP    8'd2
`define EXE_SLL_OP    8'd3
`define EXE_SLT_OP    8'd4
`define EXE_SLTU_OP   8'd5
`define EXE_XOR_OP    8'd6
`define EXE_SRL_OP    8'd7
`define EXE_SRA_OP    8'd8
`define EXE_OR_OP     8'd9
`define EXE_AND_OP    8'd10
`define EXE_LUI_OP    8'd11
`define EXE_AUIPC_OP  8'd12
`define EXE_JAL_OP    8'd13
`define EXE_JALR_OP   8'd14
`define EXE_BEQ_OP    8'd15
`define EXE_BNE_OP    8'd16
`define EXE_BLT_OP    8'd17
`define EXE_BGE_OP    8'd18
`define EXE_BLTU_OP   8'd19
`define EXE_BGEU_OP   8'd20
`define EXE_LB_OP     8'd21
`define EXE_LH_OP     8'd22
`define EXE_LW_OP     8'd23
`define EXE_LBU_OP    8'd24
`define EXE_LHU_OP    8'd25
`define EXE_SB_OP     8'd26
`define EXE_SH_OP     8'd27
`define EXE_SW_OP     8'd28
`endif

interface id_stage_if #(
  parameter int XLEN        = 32,
  parameter int NUM_FWD     = 2,
  parameter int STALL_CNT_W = 16
);
  logic                      if_valid;
  logic                      id_ready;
  logic [31:0]               if_pc;
  logic [31:0]               if_inst;
  logic                      if_pc_invalid;
  logic                      reg1_read;
  logic                      reg2_read;
  logic [4:0]                reg1_addr;
  logic [4:0]                reg2_addr;
  logic [XLEN-1:0]           reg1_data;
  logic [XLEN-1:0]           reg2_data;
  logic [NUM_FWD-1:0]        fwd_wreg;
  logic [5*NUM_FWD-1:0]      fwd_wd;
  logic [XLEN*NUM_FWD-1:0]   fwd_wdata;
  logic [NUM_FWD-1:0]        fwd_pending;
  logic                      flush;
  logic                      ex_valid;
  logic                      ex_ready;
  logic [`AluOpBus]          aluop;
  logic [4:0]                wd;
  logic                      wreg;
  logic [XLEN-1:0]           reg1;
  logic [XLEN-1:0]           reg2;
  logic [XLEN-1:0]           imm;
  logic [31:0]               ex_pc;
  logic [31:0]               ex_inst;
  logic                      ex_pc_invalid;
  logic                      inst_invalid;
  logic                      stallreq;
  logic [STALL_CNT_W-1:0]    stall_cnt;

  modport master (
    output if_valid, if_pc, if_inst, if_pc_invalid, reg1_data, reg2_data,
           fwd_wreg, fwd_wd, fwd_wdata, fwd_pending, flush, ex_ready,
    input  id_ready, reg1_read, reg2_read, reg1_addr, reg2_addr, ex_valid,
           aluop, wd, wreg, reg1, reg2, imm, ex_pc, ex_inst, ex_pc_invalid,
           inst_invalid, stallreq, stall_cnt
  );

  modport slave (
    input  if_valid, if_pc, if_inst, if_pc_invalid, reg1_data, reg2_data,
           fwd_wreg, fwd_wd, fwd_wdata, fwd_pending, flush, ex_ready,
    output id_ready, reg1_read, reg2_read, reg1_addr, reg2_addr, ex_valid,
           aluop, wd, wreg, reg1, reg2, imm, ex_pc, ex_inst, ex_pc_invalid,
           inst_invalid, stallreq, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/id_stage.sv
// ==== id_stage : RV32 decode, operand forwarding, load-use stall, ID/EX register -- rev 1.0 ====
`default_nettype none

module id_stage #(
  parameter int XLEN        = 32,
  parameter int NUM_FWD     = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_opimm  = 7'b0010011;
  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_f7_alt    = 7'b0100000;

  logic [31:0]      w_inst;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  logic [31:0]      w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [`AluOpBus] w_aluop;
  logic             w_wreg, w_rd1, w_rd2, w_bad;
  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;
  logic [4:0]       w_wd;
  logic [XLEN:0]    w_op1, w_op2;
  logic             w_hazard, w_ready, w_accept;

  assign w_inst   = bus.if_inst;
  assign w_funct3 = w_inst[14:12];
  assign w_funct7 = w_inst[31:25];
  assign w_imm_i  = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s  = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b  = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u  = {w_inst[31:12], 12'h000};
  assign w_imm_j  = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

  always_comb begin
    w_aluop = `EXE_NOP_OP;
    w_wreg  = 1'b0;
    w_rd1   = 1'b0;
    w_rd2   = 1'b0;
    w_imm32 = 32'h0;
    w_bad   = 1'b0;
    case (w_inst[6:0])
      c_op_lui:   begin w_aluop = `EXE_LUI_OP;   w_wreg = 1'b1; w_imm32 = w_imm_u; end
      c_op_auipc: begin w_aluop = `EXE_AUIPC_OP; w_wreg = 1'b1; w_imm32 = w_imm_u; end
      c_op_jal:   begin w_aluop = `EXE_JAL_OP;   w_wreg = 1'b1; w_imm32 = w_imm_j; end
      c_op_jalr: begin
        w_aluop = `EXE_JALR_OP; w_wreg = 1'b1; w_rd1 = 1'b1; w_imm32 = w_imm_i;
        w_bad   = (w_funct3 != 3'b000);
      end
      c_op_branch: begin
        w_rd1 = 1'b1; w_rd2 = 1'b1; w_imm32 = w_imm_b;
        case (w_funct3)
          3'b000:  w_aluop = `EXE_BEQ_OP;
          3'b001:  w_aluop = `EXE_BNE_OP;
          3'b100:  w_aluop = `EXE_BLT_OP;
          3'b101:  w_aluop = `EXE_BGE_OP;
          3'b110:  w_aluop = `EXE_BLTU_OP;
          3'b111:  w_aluop = `EXE_BGEU_OP;
          default: w_bad   = 1'b1;
        endcase
      end
      c_op_load: begin
        w_rd1 = 1'b1; w_wreg = 1'b1; w_imm32 = w_imm_i;
        case (w_funct3)
          3'b000:  w_aluop = `EXE_LB_OP;
          3'b001:  w_aluop = `EXE_LH_OP;
          3'b010:  w_aluop = `EXE_LW_OP;
          3'b100:  w_aluop = `EXE_LBU_OP;
          3'b101:  w_aluop = `EXE_LHU_OP;
          default: w_bad   = 1'b1;
        endcase
      end
      c_op_store: begin
        w_rd1 = 1'b1; w_rd2 = 1'b1; w_imm32 = w_imm_s;
        case (w_funct3)
          3'b000:  w_aluop = `EXE_SB_OP;
          3'b001:  w_aluop = `EXE_SH_OP;
          3'b010:  w_aluop = `EXE_SW_OP;
          default: w_bad   = 1'b1;
        endcase
      end
      c_op_opimm: begin
        w_rd1 = 1'b1; w_wreg = 1'b1; w_imm32 = w_imm_i;
        case (w_funct3)
          3'b000: w_aluop = `EXE_ADD_OP;
          3'b010: w_aluop = `EXE_SLT_OP;
          3'b011: w_aluop = `EXE_SLTU_OP;
          3'b100: w_aluop = `EXE_XOR_OP;
          3'b110: w_aluop = `EXE_OR_OP;
          3'b111: w_aluop = `EXE_AND_OP;
          3'b001: if (w_funct7 == 7'b0) w_aluop = `EXE_SLL_OP; else w_bad = 1'b1;
          default: begin
            if (w_funct7 == 7'b0)           w_aluop = `EXE_SRL_OP;
            else if (w_funct7 == c_f7_alt)  w_aluop = `EXE_SRA_OP;
            else                            w_bad   = 1'b1;
          end
        endcase
      end
      c_op_op: begin
        w_rd1 = 1'b1; w_rd2 = 1'b1; w_wreg = 1'b1;
        if (w_funct7 == 7'b0) begin
          case (w_funct3)
            3'b000:  w_aluop = `EXE_ADD_OP;
            3'b001:  w_aluop = `EXE_SLL_OP;
            3'b010:  w_aluop = `EXE_SLT_OP;
            3'b011:  w_aluop = `EXE_SLTU_OP;
            3'b100:  w_aluop = `EXE_XOR_OP;
            3'b101:  w_aluop = `EXE_SRL_OP;
            3'b110:  w_aluop = `EXE_OR_OP;
            default: w_aluop = `EXE_AND_OP;
          endcase
        end else if (w_funct7 == c_f7_alt && w_funct3 == 3'b000) begin
          w_aluop = `EXE_SUB_OP;
        end else if (w_funct7 == c_f7_alt && w_funct3 == 3'b101) begin
          w_aluop = `EXE_SRA_OP;
        end else begin
          w_bad = 1'b1;
        end
      end
      default: w_bad = 1'b1;
    endcase
    // Undecodable words still issue, but must not read, write or look like an op.
    if (w_bad) begin
      w_aluop = `EXE_NOP_OP;
      w_wreg  = 1'b0;
      w_rd1   = 1'b0;
      w_rd2   = 1'b0;
      w_imm32 = 32'h0;
    end
  end

  assign w_imm = XLEN'($signed(w_imm32));
  assign w_wd  = w_wreg ? w_inst[11:7] : 5'd0;

  // Returns {hazard, data}; the lowest-indexed matching source wins.
  function automatic logic [XLEN:0] resolve(
    input logic                    rd,
    input logic [4:0]              addr,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD-1:0]      wreg,
    input logic [5*NUM_FWD-1:0]    wd,
    input logic [XLEN*NUM_FWD-1:0] wdata,
    input logic [NUM_FWD-1:0]      pend
  );
    logic          found;
    logic [XLEN:0] res;
    found = 1'b0;
    res   = {1'b0, rf};
    if (!rd || addr == 5'd0) begin
      found = 1'b1;
      res   = '0;
    end
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!found && wreg[i] && wd[5*i +: 5] == addr) begin
        found = 1'b1;
        res   = pend[i] ? {1'b1, {XLEN{1'b0}}} : {1'b0, wdata[XLEN*i +: XLEN]};
      end
    end
    return res;
  endfunction

  assign w_op1 = resolve(w_rd1, w_inst[19:15], bus.reg1_data, bus.fwd_wreg, bus.fwd_wd,
                         bus.fwd_wdata, bus.fwd_pending);
  assign w_op2 = resolve(w_rd2, w_inst[24:20], bus.reg2_data, bus.fwd_wreg, bus.fwd_wd,
                         bus.fwd_wdata, bus.fwd_pending);

  logic                   r_ex_valid;
  logic [`AluOpBus]       r_aluop;
  logic [4:0]             r_wd;
  logic                   r_wreg;
  logic [XLEN-1:0]        r_reg1, r_reg2, r_imm;
  logic [31:0]            r_pc, r_inst;
  logic                   r_pc_invalid, r_inst_invalid;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_hazard = bus.if_valid && (w_op1[XLEN] || w_op2[XLEN]);
  assign w_ready  = (rst != `RstEnable) && !bus.flush && !w_hazard &&
                    (!r_ex_valid || bus.ex_ready);
  assign w_accept = bus.if_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      r_ex_valid     <= 1'b0;
      r_aluop        <= `EXE_NOP_OP;
      r_wd           <= 5'd0;
      r_wreg         <= 1'b0;
      r_reg1         <= '0;
      r_reg2         <= '0;
      r_imm          <= '0;
      r_pc           <= 32'h0;
      r_inst         <= 32'h0;
      r_pc_invalid   <= 1'b0;
      r_inst_invalid <= `InstValid;
      r_stall_cnt    <= '0;
    end else begin
      if (w_hazard && r_stall_cnt != {STALL_CNT_W{1'b1}})
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (bus.flush) begin
        r_ex_valid <= 1'b0;
      end else if (w_accept) begin
        r_ex_valid     <= 1'b1;
        r_aluop        <= w_aluop;
        r_wd           <= w_wd;
        r_wreg         <= w_wreg;
        r_reg1         <= w_op1[XLEN-1:0];
        r_reg2         <= w_op2[XLEN-1:0];
        r_imm          <= w_imm;
        r_pc           <= bus.if_pc;
        r_inst         <= w_inst;
        r_pc_invalid   <= bus.if_pc_invalid;
        r_inst_invalid <= w_bad ? `InstInvalid : `InstValid;
      end else if (bus.ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign bus.id_ready      = w_ready;
  assign bus.reg1_read     = w_rd1;
  assign bus.reg2_read     = w_rd2;
  assign bus.reg1_addr     = w_inst[19:15];
  assign bus.reg2_addr     = w_inst[24:20];
  assign bus.stallreq      = w_hazard;
  assign bus.ex_valid      = r_ex_valid;
  assign bus.aluop         = r_aluop;
  assign bus.wd            = r_wd;
  assign bus.wreg          = r_wreg;
  assign bus.reg1          = r_reg1;
  assign bus.reg2          = r_reg2;
  assign bus.imm           = r_imm;
  assign bus.ex_pc         = r_pc;
  assign bus.ex_inst       = r_inst;
  assign bus.ex_pc_invalid = r_pc_invalid;
  assign bus.inst_invalid  = r_inst_invalid;
  assign bus.stall_cnt     = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ==== tb_id_stage : directed vector bench for id_stage -- rev 1.0 ====
`default_nettype none

module tb_id_stage;
  localparam int XLEN = 32;
  localparam int NUM_FWD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .STALL_CNT_W(16)) bus ();
  id_stage_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .STALL_CNT_W(2))  bus2 ();

  id_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .STALL_CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  id_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .STALL_CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Narrow-counter copy sees the same stimulus so saturation is reachable quickly.
  assign bus2.if_valid      = bus.if_valid;
  assign bus2.if_pc         = bus.if_pc;
  assign bus2.if_inst       = bus.if_inst;
  assign bus2.if_pc_invalid = bus.if_pc_invalid;
  assign bus2.fwd_wreg      = bus.fwd_wreg;
  assign bus2.fwd_wd        = bus.fwd_wd;
  assign bus2.fwd_wdata     = bus.fwd_wdata;
  assign bus2.fwd_pending   = bus.fwd_pending;
  assign bus2.flush         = bus.flush;
  assign bus2.ex_ready      = bus.ex_ready;

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    case (a)
      5'd1:    return 32'd5;
      5'd2:    return 32'd7;
      default: return 32'h1000 + {27'd0, a};
    endcase
  endfunction

  always_comb begin
    bus.reg1_data  = rf_val(bus.reg1_addr);
    bus.reg2_data  = rf_val(bus.reg2_addr);
    bus2.reg1_data = rf_val(bus2.reg1_addr);
    bus2.reg2_data = rf_val(bus2.reg2_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
  endtask

  typedef struct packed {
    logic [31:0] inst;
    logic [7:0]  aluop;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic        inv;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{32'h002081B3, `EXE_ADD_OP,  5'd3, 1'b1, 32'd5, 32'd7, 32'h0,        `InstValid};
    tbl[1] = '{32'h402082B3, `EXE_SUB_OP,  5'd5, 1'b1, 32'd5, 32'd7, 32'h0,        `InstValid};
    tbl[2] = '{32'hFFF08213, `EXE_ADD_OP,  5'd4, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, `InstValid};
    tbl[3] = '{32'hFE208CE3, `EXE_BEQ_OP,  5'd0, 1'b0, 32'd5, 32'd7, 32'hFFFFFFF8, `InstValid};
    tbl[4] = '{32'h12345337, `EXE_LUI_OP,  5'd6, 1'b1, 32'd0, 32'd0, 32'h12345000, `InstValid};
    tbl[5] = '{32'h0020A423, `EXE_SW_OP,   5'd0, 1'b0, 32'd5, 32'd7, 32'h8,        `InstValid};
    tbl[6] = '{32'hFFC0A383, `EXE_LW_OP,   5'd7, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFC, `InstValid};
    tbl[7] = '{32'h010000EF, `EXE_JAL_OP,  5'd1, 1'b1, 32'd0, 32'd0, 32'h10,       `InstValid};
    tbl[8] = '{32'h4030D413, `EXE_SRA_OP,  5'd8, 1'b1, 32'd5, 32'd0, 32'h403,      `InstValid};
    tbl[9] = '{32'h0000007F, `EXE_NOP_OP,  5'd0, 1'b0, 32'd0, 32'd0, 32'h0,        `InstInvalid};

    rst = 1'b1;
    bus.if_valid = 1'b0; bus.if_pc = 32'h0; bus.if_inst = 32'h0; bus.if_pc_invalid = 1'b0;
    bus.fwd_wreg = '0; bus.fwd_wd = '0; bus.fwd_wdata = '0; bus.fwd_pending = '0;
    bus.flush = 1'b0; bus.ex_ready = 1'b1;

    repeat (2) tick();
    check("rst.ex_valid",  64'(bus.ex_valid), 64'(1'b0));
    check("rst.aluop",     64'(bus.aluop), 64'(`EXE_NOP_OP));
    check("rst.stall_cnt", 64'(bus.stall_cnt), 64'd0);
    check("rst.id_ready",  64'(bus.id_ready), 64'(1'b0));
    rst = 1'b0;
    #1;
    check("idle.id_ready", 64'(bus.id_ready), 64'(1'b1));

    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].inst, 32'h100 + 32'(4 * i));
      #1;
      check($sformatf("v%0d.id_ready", i), 64'(bus.id_ready), 64'(1'b1));
      tick();
      check($sformatf("v%0d.ex_valid", i), 64'(bus.ex_valid), 64'(1'b1));
      check($sformatf("v%0d.aluop", i),    64'(bus.aluop), 64'(tbl[i].aluop));
      check($sformatf("v%0d.wd", i),       64'(bus.wd), 64'(tbl[i].wd));
      check($sformatf("v%0d.wreg", i),     64'(bus.wreg), 64'(tbl[i].wreg));
      check($sformatf("v%0d.reg1", i),     64'(bus.reg1), 64'(tbl[i].r1));
      check($sformatf("v%0d.reg2", i),     64'(bus.reg2), 64'(tbl[i].r2));
      check($sformatf("v%0d.imm", i),      64'(bus.imm), 64'(tbl[i].imm));
      check($sformatf("v%0d.invalid", i),  64'(bus.inst_invalid), 64'(tbl[i].inv));
      check($sformatf("v%0d.pc", i),       64'(bus.ex_pc), 64'(32'h100 + 32'(4 * i)));
    end

    // Forwarding priority: source 0 beats source 1 on the same register.
    bus.fwd_wreg = 2'b11; bus.fwd_wd = {5'd1, 5'd1}; bus.fwd_wdata = {32'hBB, 32'hAA};
    issue(32'hFFF08213, 32'h200);
    tick();
    check("fwd.prio_reg1", 64'(bus.reg1), 64'h0AA);
    check("fwd.imm",       64'(bus.imm), 64'hFFFFFFFF);
    bus.fwd_wreg = 2'b10;
    tick();
    check("fwd.src1_reg1", 64'(bus.reg1), 64'h0BB);

    // Load-use stall on rs2 of a store for three cycles.
    bus.fwd_wreg = 2'b01; bus.fwd_wd = {5'd0, 5'd2}; bus.fwd_wdata = {32'h0, 32'h77};
    bus.fwd_pending = 2'b01;
    issue(32'h0020A423, 32'h204);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d.id_ready", k), 64'(bus.id_ready), 64'(1'b0));
      check($sformatf("stall%0d.stallreq", k), 64'(bus.stallreq), 64'(1'b1));
      tick();
      check($sformatf("stall%0d.bubble", k),   64'(bus.ex_valid), 64'(1'b0));
    end
    bus.fwd_pending = 2'b00;
    #1;
    check("stall.release_ready", 64'(bus.id_ready), 64'(1'b1));
    check("stall.release_req",   64'(bus.stallreq), 64'(1'b0));
    tick();
    check("stall.ex_valid",  64'(bus.ex_valid), 64'(1'b1));
    check("stall.aluop",     64'(bus.aluop), 64'(`EXE_SW_OP));
    check("stall.reg1",      64'(bus.reg1), 64'd5);
    check("stall.reg2",      64'(bus.reg2), 64'h77);
    check("stall.cnt",       64'(bus.stall_cnt), 64'd3);
    check("stall.cnt_sat",   64'(bus2.stall_cnt), 64'd3);

    // x0 never forwards or stalls, even from a pending source.
    bus.fwd_wd = {5'd0, 5'd0}; bus.fwd_wdata = {32'h0, 32'h55}; bus.fwd_pending = 2'b01;
    bus.if_pc_invalid = 1'b1;
    issue(32'h000002B3, 32'h208);
    #1;
    check("x0.stallreq", 64'(bus.stallreq), 64'(1'b0));
    tick();
    check("x0.reg1",       64'(bus.reg1), 64'd0);
    check("x0.reg2",       64'(bus.reg2), 64'd0);
    check("x0.pc_invalid", 64'(bus.ex_pc_invalid), 64'(1'b1));
    check("x0.cnt",        64'(bus.stall_cnt), 64'd3);
    bus.fwd_wreg = '0; bus.fwd_pending = '0; bus.if_pc_invalid = 1'b0;

    // Backpressure holds the entry, then flush drops it.
    issue(32'h002081B3, 32'h300);
    tick();
    bus.ex_ready = 1'b0;
    issue(32'h402082B3, 32'h304);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("hold%0d.id_ready", k), 64'(bus.id_ready), 64'(1'b0));
      tick();
      check($sformatf("hold%0d.ex_valid", k), 64'(bus.ex_valid), 64'(1'b1));
      check($sformatf("hold%0d.aluop", k),    64'(bus.aluop), 64'(`EXE_ADD_OP));
      check($sformatf("hold%0d.wd", k),       64'(bus.wd), 64'd3);
      check($sformatf("hold%0d.pc", k),       64'(bus.ex_pc), 64'h300);
    end
    bus.flush = 1'b1;
    tick();
    check("flush.ex_valid", 64'(bus.ex_valid), 64'(1'b0));
    bus.flush = 1'b0;
    tick();
    check("after_flush.aluop", 64'(bus.aluop), 64'(`EXE_SUB_OP));
    check("after_flush.wd",    64'(bus.wd), 64'd5);
    bus.ex_ready = 1'b1; bus.flush = 1'b1;
    issue(32'h12345337, 32'h308);
    #1;
    check("flush_acc.id_ready", 64'(bus.id_ready), 64'(1'b0));
    tick();
    check("flush_acc.ex_valid", 64'(bus.ex_valid), 64'(1'b0));
    bus.flush = 1'b0; bus.if_valid = 1'b0;
    tick();
    check("flush_acc.dropped", 64'(bus.ex_valid), 64'(1'b0));

    // Reset while holding and stalling.
    issue(32'h002081B3, 32'h400);
    tick();
    bus.ex_ready = 1'b0;
    bus.fwd_wreg = 2'b01; bus.fwd_wd = {5'd0, 5'd1}; bus.fwd_pending = 2'b01;
    issue(32'hFFF08213, 32'h404);
    repeat (2) tick();
    check("mid.ex_valid", 64'(bus.ex_valid), 64'(1'b1));
    check("mid.cnt",      64'(bus.stall_cnt), 64'd5);
    check("mid.cnt_sat",  64'(bus2.stall_cnt), 64'd3);
    rst = 1'b1;
    tick();
    check("rst2.ex_valid", 64'(bus.ex_valid), 64'(1'b0));
    check("rst2.data",     {bus.reg1, bus.reg2}, 64'h0);
    check("rst2.imm_pc",   {bus.imm, bus.ex_pc}, 64'h0);
    check("rst2.inst",     64'(bus.ex_inst), 64'h0);
    check("rst2.aluop",    64'(bus.aluop), 64'(`EXE_NOP_OP));
    check("rst2.wd_wreg",  64'({bus.wd, bus.wreg}), 64'h0);
    check("rst2.flags",    64'({bus.inst_invalid, bus.ex_pc_invalid}), 64'({`InstValid, 1'b0}));
    check("rst2.cnt",      64'(bus.stall_cnt), 64'd0);
    check("rst2.cnt2",     64'(bus2.stall_cnt), 64'd0);
    rst = 1'b0; bus.if_valid = 1'b0; bus.fwd_wreg = '0; bus.fwd_pending = '0; bus.ex_ready = 1'b1;
    tick();
    check("post_rst.ex_valid", 64'(bus.ex_valid), 64'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
